// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_tx among N_REQ byte producers.
// Optional BUSY watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done,
    output logic               busy,
    output logic               timeout_err
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] ptr_after;
    logic          win_found;
    logic          arb_go;
    logic          done_go;
    logic          abort_go;
    logic [7:0]    req_bytes [N_REQ];
    int            scan_idx;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be positive");
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    // Scan downward in offset so the last hit is the one closest to rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (req[scan_idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PW-1:0];
            end
        end
    end

    assign ptr_after = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);

    // No arbitration while ack or timeout_err is pulsing: guarantees an idle gap
    // and gives the previous owner a cycle to drop its request.
    assign arb_go  = (state == IDLE) && win_found && (ack == '0) && !timeout_err;
    assign done_go = (state == BUSY) && tx_done;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        to_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            to_err <= abort_go;
            if (state == START) begin
                to_cnt <= '0;
            end else if (state == BUSY) begin
                to_cnt <= to_cnt + 32'd1;
            end
        end
    end

    assign abort_go    = (state == BUSY) && !tx_done && (to_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout_err = to_err;
`else
    assign abort_go    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (arb_go) begin
                    state_next = START;
                end
            end
            START: begin
                tx_start   = 1'b1;
                busy       = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (done_go || abort_go) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant   <= '0;
            ack     <= '0;
            tx_data <= 8'h00;
            rr_ptr  <= '0;
            owner   <= '0;
        end else begin
            ack <= '0;
            if (arb_go) begin
                grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                owner   <= win_idx;
                tx_data <= req_bytes[win_idx];
            end
            if (done_go) begin
                ack    <= grant;
                grant  <= '0;
                rr_ptr <= ptr_after;
            end else if (abort_go) begin
                grant  <= '0;
                rr_ptr <= ptr_after;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected {grant, byte} per tx_start,
// plus scenario tasks for latency, round-robin order, drop, spurious done and reset.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done = 1'b0;
    logic           busy;
    logic           timeout_err;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic [11:0] exp_q[$];

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Scoreboard: every tx_start must match the next expected {grant, tx_data}.
    always @(negedge clk) begin : sb_mon
        logic [11:0] e;
        if (reset && tx_start) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_start: got grant=%b data=%h, required no tx_start", grant, tx_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant, tx_data} !== e)
                    $display("FAIL sb_start: got grant=%b data=%h, required grant=%b data=%h",
                             grant, tx_data, e[11:8], e[7:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic release_req(input int i);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    // Behaves like uart_tx: waits for tx_start, spends hold cycles, pulses tx_done.
    task automatic serve(input int hold, input logic [N-1:0] drop_mask,
                         output bit got, output int start_cyc, output int ack_cyc,
                         output logic [N-1:0] ack_val, output logic [N-1:0] grant_after,
                         output logic [7:0] data_at_ack);
        got = 1'b0;
        start_cyc = -1;
        ack_cyc = -1;
        ack_val = 'x;
        grant_after = 'x;
        data_at_ack = 'x;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (tx_start) got = 1'b1;
        end
        if (!got) return;
        start_cyc = cyc;
        @(posedge clk); #1;
        if (drop_mask != '0) begin
            req = req & ~drop_mask;
            for (int i = 0; i < N; i++)
                if (drop_mask[i]) req_data[8*i +: 8] = 8'hFF;
        end
        repeat (hold) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        ack_val = ack;
        ack_cyc = cyc;
        grant_after = grant;
        data_at_ack = tx_data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '0;
        req_data = '0;
        tx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({grant, ack, tx_start, busy, timeout_err} !== 11'd0)
            $display("FAIL reset_ctrl: got %b, required 0", {grant, ack, tx_start, busy, timeout_err});
        else n_pass++;
        n_checks++;
        if (tx_data !== 8'h00) $display("FAIL reset_data: got %h, required 00", tx_data);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant !== '0) $display("FAIL idle_no_req: got busy=%b grant=%b, required 0/0", busy, grant);
        else n_pass++;
    endtask

    task automatic test_contention();
        bit got;
        int s_c, a_c, prev_ack;
        logic [N-1:0] a_v, g_a, oh;
        logic [7:0] d_a;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_byte(i, 8'h10 + 8'(i));
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << (j % 4);
            exp_q.push_back({oh, 8'h10 + 8'(j % 4)});
        end
        prev_ack = -1;
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << (j % 4);
            serve(2 + j, '0, got, s_c, a_c, a_v, g_a, d_a);
            n_checks++;
            if (!got) $display("FAIL contention_start%0d: got no tx_start, required one", j);
            else if (a_v !== oh) $display("FAIL contention_ack%0d: got %b, required %b", j, a_v, oh);
            else n_pass++;
            if (prev_ack >= 0) begin
                n_checks++;
                if (s_c - prev_ack !== 2) $display("FAIL b2b_gap%0d: got %0d, required 2", j, s_c - prev_ack);
                else n_pass++;
            end
            prev_ack = a_c;
        end
        @(posedge clk); #1 req = '0;
    endtask

    task automatic test_single();
        bit got;
        int s_c, a_c, req_cyc;
        logic [N-1:0] a_v, g_a;
        logic [7:0] d_a;
        @(posedge clk); #1;
        set_byte(2, 8'hA5);
        req = 4'b0100;
        req_cyc = cyc;
        exp_q.push_back({4'b0100, 8'hA5});
        serve(3, '0, got, s_c, a_c, a_v, g_a, d_a);
        n_checks++;
        if (s_c - req_cyc !== 1) $display("FAIL single_latency: got %0d, required 1", s_c - req_cyc);
        else n_pass++;
        n_checks++;
        if (a_v !== 4'b0100 || g_a !== '0)
            $display("FAIL single_ack: got ack=%b grant=%b, required 0100/0000", a_v, g_a);
        else n_pass++;
        release_req(2);
        @(negedge clk);
        n_checks++;
        if (ack !== '0) $display("FAIL ack_width: got %b, required 0000", ack);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit got;
        int s_c, a_c;
        int order[3] = '{3, 0, 1};
        logic [N-1:0] a_v, g_a, oh;
        logic [7:0] d_a;
        @(posedge clk); #1;
        set_byte(0, 8'h30);
        set_byte(1, 8'h31);
        set_byte(3, 8'h33);
        req = 4'b1011;
        for (int j = 0; j < 3; j++) begin
            oh = 4'b0001 << order[j];
            exp_q.push_back({oh, 8'h30 + 8'(order[j])});
        end
        for (int j = 0; j < 3; j++) begin
            oh = 4'b0001 << order[j];
            serve(1, '0, got, s_c, a_c, a_v, g_a, d_a);
            n_checks++;
            if (a_v !== oh) $display("FAIL wrap_ack%0d: got %b, required %b", j, a_v, oh);
            else n_pass++;
            release_req(order[j]);
        end
    endtask

    task automatic test_drop();
        bit got;
        int s_c, a_c;
        logic [N-1:0] a_v, g_a;
        logic [7:0] d_a;
        @(posedge clk); #1;
        set_byte(1, 8'h5C);
        req = 4'b0010;
        exp_q.push_back({4'b0010, 8'h5C});
        serve(4, 4'b0010, got, s_c, a_c, a_v, g_a, d_a);
        n_checks++;
        if (a_v !== 4'b0010 || d_a !== 8'h5C)
            $display("FAIL drop: got ack=%b data=%h, required 0010/5c", a_v, d_a);
        else n_pass++;
    endtask

    task automatic test_spurious_done();
        bit got;
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== '0 || busy !== 1'b0) $display("FAIL done_in_idle: got ack=%b busy=%b, required 0000/0", ack, busy);
        else n_pass++;
        @(posedge clk); #1;
        set_byte(0, 8'h77);
        req = 4'b0001;
        exp_q.push_back({4'b0001, 8'h77});
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (tx_start) got = 1'b1;
        end
        tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!got || ack !== '0 || busy !== 1'b1)
            $display("FAIL done_in_start: got start=%b ack=%b busy=%b, required 1/0000/1", got, ack, busy);
        else n_pass++;
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 4'b0001) $display("FAIL done_after_start: got %b, required 0001", ack);
        else n_pass++;
        release_req(0);
    endtask

    task automatic test_reset_mid();
        bit got;
        int s_c, a_c;
        logic [N-1:0] a_v, g_a;
        logic [7:0] d_a;
        @(posedge clk); #1;
        set_byte(1, 8'h42);
        req = 4'b0010;
        exp_q.push_back({4'b0010, 8'h42});
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (tx_start) got = 1'b1;
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (!got || {grant, ack, tx_start, busy, timeout_err} !== 11'd0 || tx_data !== 8'h00)
            $display("FAIL reset_mid: got start=%b outs=%b data=%h, required 1/0/00",
                     got, {grant, ack, tx_start, busy, timeout_err}, tx_data);
        else n_pass++;
        exp_q.push_back({4'b0010, 8'h42});
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        serve(2, '0, got, s_c, a_c, a_v, g_a, d_a);
        n_checks++;
        if (a_v !== 4'b0010) $display("FAIL reset_mid_fresh: got %b, required 0010", a_v);
        else n_pass++;
        release_req(1);
    endtask

    task automatic test_reset_priority();
        bit got;
        int s_c, a_c;
        logic [N-1:0] a_v, g_a;
        logic [7:0] d_a;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        set_byte(0, 8'hE0);
        set_byte(3, 8'hE3);
        req = 4'b1001;
        exp_q.push_back({4'b0001, 8'hE0});
        exp_q.push_back({4'b1000, 8'hE3});
        reset = 1'b1;
        serve(1, '0, got, s_c, a_c, a_v, g_a, d_a);
        n_checks++;
        if (a_v !== 4'b0001) $display("FAIL prio_first: got %b, required 0001", a_v);
        else n_pass++;
        release_req(0);
        serve(1, '0, got, s_c, a_c, a_v, g_a, d_a);
        n_checks++;
        if (a_v !== 4'b1000) $display("FAIL prio_second: got %b, required 1000", a_v);
        else n_pass++;
        release_req(3);
    endtask

    task automatic test_stuck_busy();
        bit got;
        int s_c, bad, err_cyc;
        @(posedge clk); #1;
        set_byte(2, 8'h99);
        req = 4'b0100;
        exp_q.push_back({4'b0100, 8'h99});
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (tx_start) got = 1'b1;
        end
        s_c = cyc;
        bad = 0;
        err_cyc = -1;
`ifdef UART_ARB_TIMEOUT_EN
        set_byte(0, 8'h0A);
        req[0] = 1'b1;
        exp_q.push_back({4'b0001, 8'h0A});
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (timeout_err && err_cyc < 0) err_cyc = cyc;
            if (ack !== '0) bad++;
        end
        n_checks++;
        if (!got || err_cyc !== s_c + 51 || bad != 0)
            $display("FAIL timeout: got err_cyc=%0d acks=%0d, required %0d/0", err_cyc, bad, s_c + 51);
        else n_pass++;
`else
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || timeout_err !== 1'b0 || ack !== '0) bad++;
        end
        n_checks++;
        if (!got || bad != 0 || err_cyc != -1)
            $display("FAIL stuck_busy: got start=%b bad_cycles=%0d, required 1/0", got, bad);
        else n_pass++;
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        req = '0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_drop();
        test_spurious_done();
        test_reset_mid();
        test_reset_priority();
        test_stuck_busy();
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
